// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the ALU2 shifter and its sequencer.
//   XLEN                : datapath width
//   MAX_SHIFT_PER_CYCLE : bit positions the multi-cycle shifter covers per cycle
package core_config_pkg;
    localparam int XLEN                = 32;
    localparam int MAX_SHIFT_PER_CYCLE = 3;
endpackage

// File: rtl/shift_sequencer_if.sv
// Bundle of the shift sequencer's issue, shifter and writeback signals.
//   flush                       : pipeline flush
//   issue_*                     : decoded shift instruction offer/accept
//   sh_*                        : start/done protocol towards the shifter
//   wb_*                        : result writeback offer/accept
// Handshakes (issue and wb): a transfer happens on a rising clk edge where
// valid and ready are both high; the producer holds valid and its payload
// stable until that edge, and ready may depend combinationally on state.
// The slave modport is the sequencer's view; master is the environment's view.
interface shift_sequencer_if
    import core_config_pkg::*;
#(
    parameter int TAG_W = 5
) ();
    localparam int SW = $clog2(XLEN);

    logic             flush;
    logic             issue_valid;
    logic             issue_ready;
    logic [2:0]       issue_funct3;
    logic             issue_funct7_5;
    logic [XLEN-1:0]  issue_rs1;
    logic [XLEN-1:0]  issue_rs2;
    logic [TAG_W-1:0] issue_rd;
    logic             sh_start;
    logic [XLEN-1:0]  sh_data;
    logic [SW-1:0]    sh_amount;
    logic             sh_left;
    logic             sh_arith;
    logic [XLEN-1:0]  sh_result;
    logic             sh_done;
    logic             wb_valid;
    logic             wb_ready;
    logic [XLEN-1:0]  wb_data;
    logic [TAG_W-1:0] wb_rd;
    logic             wb_err;

    modport slave (
        input  flush, issue_valid, issue_funct3, issue_funct7_5, issue_rs1,
               issue_rs2, issue_rd, sh_result, sh_done, wb_ready,
        output issue_ready, sh_start, sh_data, sh_amount, sh_left, sh_arith,
               wb_valid, wb_data, wb_rd, wb_err
    );

    modport master (
        output flush, issue_valid, issue_funct3, issue_funct7_5, issue_rs1,
               issue_rs2, issue_rd, sh_result, sh_done, wb_ready,
        input  issue_ready, sh_start, sh_data, sh_amount, sh_left, sh_arith,
               wb_valid, wb_data, wb_rd, wb_err
    );
endinterface

// File: rtl/shift_sequencer.sv
// Issue-side controller for the ALU2 multi-cycle shifter. Accepts one
// SLL/SRL/SRA instruction, runs the shifter's start/done protocol and returns
// the result with its destination tag. Zero-amount shifts and illegal
// encodings complete locally; flushes drain any shift already started.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : shift_sequencer_if slave (flush, issue_*, sh_*, wb_*)
//   dbg_state  : current FSM state (IDLE=0 START=1 WAIT=2 DRAIN=3 WB=4)
module shift_sequencer
    import core_config_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_sequencer_if.slave  bus,
    output logic [2:0]        dbg_state
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        WB    = 3'd4
    } state_t;

    state_t           state;
    logic [XLEN-1:0]  rs1_q;
    logic [SW-1:0]    amt_q;
    logic             left_q;
    logic             arith_q;
    logic             start_q;
    logic             wb_valid_q;
    logic [XLEN-1:0]  wb_data_q;
    logic [TAG_W-1:0] wb_rd_q;
    logic             wb_err_q;

    logic             issue_ready;
    logic             accept;
    logic             illegal;
    logic [SW-1:0]    amt_in;
    logic             unused_rs2_hi;

    // Only the low SW bits of rs2 carry the shift amount.
    assign amt_in        = bus.issue_rs2[SW-1:0];
    assign unused_rs2_hi = ^bus.issue_rs2[XLEN-1:SW];

    assign illegal = !((bus.issue_funct3 == 3'b001) || (bus.issue_funct3 == 3'b101))
                     || ((bus.issue_funct3 == 3'b001) && bus.issue_funct7_5);

    assign issue_ready = (state == IDLE) && !bus.flush;
    assign accept      = bus.issue_valid && issue_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rs1_q      <= '0;
            amt_q      <= '0;
            left_q     <= 1'b0;
            arith_q    <= 1'b0;
            start_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rs1_q    <= bus.issue_rs1;
                        amt_q    <= amt_in;
                        wb_rd_q  <= bus.issue_rd;
                        left_q   <= (bus.issue_funct3 == 3'b001);
                        arith_q  <= (bus.issue_funct3 == 3'b101) && bus.issue_funct7_5;
                        wb_err_q <= 1'b0;
                        if (illegal) begin
                            wb_err_q   <= 1'b1;
                            wb_data_q  <= '0;
                            wb_valid_q <= 1'b1;
                            state      <= WB;
                        end else if (amt_in == '0) begin
                            // Zero shift is the identity; skip the shifter.
                            wb_data_q  <= bus.issue_rs1;
                            wb_valid_q <= 1'b1;
                            state      <= WB;
                        end else begin
                            start_q <= 1'b1;
                            state   <= START;
                        end
                    end
                end
                START: begin
                    // sh_done may still be high from the previous shift here;
                    // it is deliberately not looked at until WAIT.
                    state <= bus.flush ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (bus.sh_done) begin
                        if (bus.flush) begin
                            state <= IDLE;
                        end else begin
                            wb_data_q  <= bus.sh_result;
                            wb_valid_q <= 1'b1;
                            state      <= WB;
                        end
                    end else if (bus.flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The shifter must finish before it can be restarted.
                    if (bus.sh_done) state <= IDLE;
                end
                WB: begin
                    // Flush wins over a same-cycle handshake.
                    if (bus.flush || bus.wb_ready) begin
                        wb_valid_q <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.sh_start    = start_q;
    assign bus.sh_data     = rs1_q;
    assign bus.sh_amount   = amt_q;
    assign bus.sh_left     = left_q;
    assign bus.sh_arith    = arith_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_err      = wb_err_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
    import core_config_pkg::*;
    localparam int SW = $clog2(XLEN);
    localparam int M  = MAX_SHIFT_PER_CYCLE;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_sequencer_if #(.TAG_W(5)) bus ();
    logic [2:0] dbg_state;

    shift_sequencer #(.TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- shifter model ----------------
    // Done is sticky, cleared on the edge that samples start, and rises
    // ceil(n/M)+2 cycles after the start cycle.
    logic [XLEN-1:0] m_res  = '0;
    logic            m_done = 1'b0;
    int              m_cnt  = 0;

    function automatic logic [XLEN-1:0] shf(input logic [XLEN-1:0] d, input logic [SW-1:0] n,
                                            input logic l, input logic ar);
        if (l) return d << n;
        if (ar) return $unsigned($signed(d) >>> n);
        return d >> n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res  <= '0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else if (bus.sh_start) begin
            m_done <= 1'b0;
            m_cnt  <= (int'(bus.sh_amount) + M - 1) / M + 1;
            m_res  <= shf(bus.sh_data, bus.sh_amount, bus.sh_left, bus.sh_arith);
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_done <= 1'b1;
        end
    end
    assign bus.sh_done   = m_done;
    assign bus.sh_result = m_res;

    // cyc equals c during cycle c; start_cyc records the cycle of each sh_start.
    int cyc = 0, start_cnt = 0, start_cyc = -1;
    always @(posedge clk) begin
        if (bus.sh_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        cyc <= cyc + 1;
    end

    // ---------------- scoreboard ----------------
    logic [XLEN-1:0] exp_q[$];
    int pass_cnt = 0, total_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    typedef struct {
        logic [2:0]      f3;
        logic            f7;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] exp_data;
        logic            exp_err;
        int              exp_lat;   // cycles from accept to first wb_valid
    } vec_t;

    function automatic vec_t mk(input logic [2:0] f3, input logic f7, input logic [XLEN-1:0] rs1,
                                input logic [XLEN-1:0] rs2, input logic [4:0] rd,
                                input logic [XLEN-1:0] ed, input logic ee, input int el);
        vec_t v;
        v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.exp_data = ed; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    // Returns with the accept edge passed, #1 into cycle a+1.
    task automatic do_issue(input vec_t v, output int a);
        int n;
        n = 0;
        @(negedge clk);
        bus.issue_funct3   = v.f3;
        bus.issue_funct7_5 = v.f7;
        bus.issue_rs1      = v.rs1;
        bus.issue_rs2      = v.rs2;
        bus.issue_rd       = v.rd;
        bus.issue_valid    = 1'b1;
        while (!bus.issue_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) chk("issue_ready_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
        a = cyc - 1;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int a, lat, s0;
        logic [XLEN-1:0] e;
        s0 = start_cnt;
        exp_q.push_back(v.exp_data);
        do_issue(v, a);
        lat = 1;
        while (!bus.wb_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = exp_q.pop_front();
        chk({nm, " latency"}, 64'(lat), 64'(v.exp_lat));
        chk({nm, " wb_data"}, 64'(bus.wb_data), 64'(e));
        chk({nm, " wb_err"}, 64'(bus.wb_err), 64'(v.exp_err));
        chk({nm, " wb_rd"}, 64'(bus.wb_rd), 64'(v.rd));
        if (v.exp_lat > 1) begin
            chk({nm, " start_count"}, 64'(start_cnt - s0), 64'(1));
            chk({nm, " start_cycle"}, 64'(start_cyc), 64'(a + 1));
        end else begin
            chk({nm, " no_start"}, 64'(start_cnt - s0), 64'(0));
        end
    endtask

    // ---------------- test ----------------
    vec_t vecs[10];

    initial begin
        int a, c;
        logic saw;
        vecs[0] = mk(3'b001, 1'b0, 32'h0000_0001, 32'h0000_0004, 5'd1, 32'h0000_0010, 1'b0, 6);
        vecs[1] = mk(3'b101, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 1'b0, 15);
        vecs[2] = mk(3'b101, 1'b0, 32'hF000_0000, 32'h0000_0025, 5'd3, 32'h0780_0000, 1'b0, 6);
        vecs[3] = mk(3'b001, 1'b0, 32'h1234_ABCD, 32'h0000_0020, 5'd4, 32'h1234_ABCD, 1'b0, 1);
        vecs[4] = mk(3'b010, 1'b0, 32'hDEAD_BEEF, 32'h0000_0003, 5'd5, 32'h0000_0000, 1'b1, 1);
        vecs[5] = mk(3'b001, 1'b1, 32'h0000_00FF, 32'h0000_0002, 5'd6, 32'h0000_0000, 1'b1, 1);
        vecs[6] = mk(3'b101, 1'b1, 32'hF000_0000, 32'h0000_0004, 5'd7, 32'hFF00_0000, 1'b0, 6);
        vecs[7] = mk(3'b101, 1'b0, 32'h8000_0000, 32'h0000_001F, 5'd8, 32'h0000_0001, 1'b0, 15);
        vecs[8] = mk(3'b001, 1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 5'd9, 32'hFFFF_FFF8, 1'b0, 5);
        vecs[9] = mk(3'b101, 1'b1, 32'h8000_0001, 32'h0000_0040, 5'd10, 32'h8000_0001, 1'b0, 1);

        bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.issue_funct3 = 3'b000;
        bus.issue_funct7_5 = 1'b0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
        bus.issue_rd = '0; bus.wb_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset wb_valid", 64'(bus.wb_valid), 64'(0));
        chk("reset wb_data", 64'(bus.wb_data), 64'(0));
        chk("reset sh_start", 64'(bus.sh_start), 64'(0));
        chk("reset issue_ready", 64'(bus.issue_ready), 64'(1));
        chk("reset state", 64'(dbg_state), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Flush in WAIT two cycles after start of a 31-bit shift.
        do_issue(vecs[1], a);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        saw = 1'b0;
        c = a + 4;
        while (!bus.issue_ready && c < a + 40) begin
            if (bus.wb_valid) saw = 1'b1;
            @(posedge clk); #1;
            c++;
        end
        chk("flush ready_return_cycle", 64'(c - a), 64'(15));
        chk("flush no_wb_valid", 64'(saw | bus.wb_valid), 64'(0));

        // Writeback back-pressure, then issue while the old done is still high.
        @(negedge clk);
        bus.wb_ready = 1'b0;
        run_vec(mk(3'b001, 1'b0, 32'h0000_0003, 32'h0000_0002, 5'd11, 32'h0000_000C, 1'b0, 5), "bp");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d", i), {31'd0, bus.wb_valid, bus.wb_data},
                {31'd0, 1'b1, 32'h0000_000C});
            chk($sformatf("bp hold_rd%0d", i), 64'(bus.wb_rd), 64'(11));
        end
        bus.wb_ready = 1'b1;
        run_vec(mk(3'b101, 1'b0, 32'h0000_0100, 32'h0000_0008, 5'd12, 32'h0000_0001, 1'b0, 7), "stale_done");

        // Flush while the result is offered: it must be dropped.
        do_issue(vecs[3], a);
        chk("wbflush valid_before", 64'(bus.wb_valid), 64'(1));
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("wbflush valid_after", 64'(bus.wb_valid), 64'(0));
        chk("wbflush state", 64'(dbg_state), 64'(0));

        // Reset in the middle of WAIT.
        do_issue(vecs[7], a);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst pre_state", 64'(dbg_state), 64'(2));
        rst_n = 1'b0;
        #1;
        chk("rst outputs", {bus.wb_valid, bus.wb_err, bus.sh_start, bus.sh_left, bus.sh_arith,
                            bus.wb_rd, bus.sh_amount}, 64'(0));
        chk("rst wb_data", 64'(bus.wb_data), 64'(0));
        chk("rst sh_data", 64'(bus.sh_data), 64'(0));
        chk("rst state", 64'(dbg_state), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(3'b001, 1'b0, 32'h0000_00A5, 32'h0000_0007, 5'd13, 32'h0000_5280, 1'b0, 7), "post_rst");

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Issue-side controller for the ALU2 multi-cycle shifter. It accepts one decoded shift instruction (SLL/SRL/SRA, register or immediate form) over a valid/ready handshake and drives the shifter's start/done protocol. It then returns the result with its destination tag over a valid/ready writeback port. Zero-amount shifts and illegal encodings complete locally without starting the shifter. Flushes are handled by draining any in-flight shift.

## Interface
- TAG_W, default 5: destination register tag width.
- XLEN and MAX_SHIFT_PER_CYCLE (M) come from core_config_pkg. SW = $clog2(XLEN).
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; kills the current instruction.
- issue_valid  in  1  instruction offered.
- issue_ready  out  1  instruction accepted when valid and ready are both high.
- issue_funct3  in  3  001 = SLL; 101 = SRL/SRA; anything else is illegal.
- issue_funct7_5  in  1  1 selects SRA for funct3 101; for SLL it must be 0.
- issue_rs1  in  XLEN  operand to shift.
- issue_rs2  in  XLEN  shift amount source; only bits [SW-1:0] are used.
- issue_rd  in  TAG_W  destination tag.
- sh_start  out  1  shifter start, one-cycle pulse.
- sh_data  out  XLEN  operand to the shifter.
- sh_amount  out  SW  shift amount to the shifter.
- sh_left  out  1  shift direction to the shifter.
- sh_arith  out  1  arithmetic-shift select to the shifter.
- sh_result  in  XLEN  shifter output.
- sh_done  in  1  shifter done flag. It is sticky: it stays high until the next start.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback stage accepts the result.
- wb_data  out  XLEN  result.
- wb_rd  out  TAG_W  destination tag.
- wb_err  out  1  illegal encoding; wb_data is 0 in this case.

## Operation
- States: IDLE, START, WAIT, DRAIN, WB. All outputs and the operand registers reset to 0; state resets to IDLE.
- issue_ready = (state == IDLE) && !flush.
- IDLE, on accept:
  - Latch rs1, rs2[SW-1:0], rd.
  - Decode: sh_left = (funct3 == 001); sh_arith = (funct3 == 101) && funct7_5.
  - Illegal encoding (funct3 not 001/101, or SLL with funct7_5 = 1): go to WB with wb_err = 1 and wb_data = 0.
  - Shift amount 0: go to WB with wb_data = rs1 (bypass; the shifter is not started).
  - Otherwise: go to START.
- START:
  - sh_start = 1 for exactly this cycle. sh_data, sh_amount, sh_left and sh_arith are driven from the latched registers.
  - Next state is WAIT, or DRAIN if flush is high.
- WAIT:
  - sh_done is sampled only in this state. A stale done during START is ignored, because the shifter clears it one cycle after start.
  - On sh_done: capture sh_result into wb_data and go to WB.
  - On flush without sh_done: go to DRAIN.
  - On flush together with sh_done: discard the result and go to IDLE.
- DRAIN: wait for sh_done, discard the result, go to IDLE. flush has no further effect here.
- WB:
  - wb_valid = 1. wb_data, wb_rd and wb_err stay stable while wb_ready is low.
  - wb_valid && wb_ready: go to IDLE.
  - flush: drop wb_valid and go to IDLE. Flush takes priority over a simultaneous handshake, so the result is not written.
- One instruction is in flight at a time. There is no overlap between WB and a new accept.

## Timing
- Accept occurs at cycle a.
- Bypass and illegal cases: wb_valid at a+1.
- Shift of n > 0:
  - sh_start at a+1.
  - Shifter sh_done at a+3+ceil(n/M).
  - wb_valid at a+4+ceil(n/M).
- Worst case, M = 3 and n = 31: wb_valid at a+15.
- With wb_ready held high, the next accept can occur one cycle after the wb handshake.
- Reset mid-operation: the shifter resets together with this block on the same rst_n, so no drain is needed after reset.

## Test plan (M = 3, XLEN = 32)
- SLL: rs1 = 0x00000001, rs2 = 4, accepted at a -> sh_start only at a+1; wb_data = 0x00000010 and wb_err = 0 at a+6.
- SRA: rs1 = 0x80000000, rs2 = 0xFFFFFFFF (amount 31) -> wb_data = 0xFFFFFFFF at a+15. SRL with rs1 = 0xF0000000, rs2 = 0x25 (amount 5) -> wb_data = 0x07800000 at a+6.
- Shift amount 0 (rs2 = 0x20) with rs1 = 0x1234ABCD -> wb_data = 0x1234ABCD at a+1; sh_start never asserts. funct3 = 010 -> wb_err = 1 and wb_data = 0 at a+1.
- Flush asserted in WAIT two cycles after sh_start for a 31-bit shift -> no wb_valid; issue_ready stays low until the cycle after sh_done, then returns high.
- wb_ready held low for 5 cycles -> wb_valid, wb_data and wb_rd stay stable. The next instruction is issued while the previous sh_done is still high, and it completes with the correct new result.
- rst_n asserted mid-WAIT -> all outputs 0 immediately; the next instruction after reset completes normally.
